// File: rtl/div_pkg.sv
// Shared definitions for the RV32M iterative divider.
//   - funct3 encodings for DIV / DIVU / REM / REMU
//   - FSM state type
//   - iteration counter width helper
package div_pkg;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the divider.
//   master (EX stage) : start, funct3, op_a, op_b, kill, cache_stall
//   slave  (divider)  : div_stall, done, result
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             kill;
   logic             cache_stall;
   logic             div_stall;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, kill, cache_stall,
      input  div_stall, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, kill, cache_stall,
      output div_stall, done, result
   );
endinterface

// File: rtl/lzc.sv
// Leading-zero counter used by the divider's early-out launch.
//   value : operand to scan (MSB first)
//   count : number of leading zeros, WIDTH when value is 0
module lzc #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CW-1:0]    count
);

   logic found;

   always_comb begin
      count = CW'(WIDTH);
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && value[i]) begin
            count = CW'(WIDTH - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : div_unit_if.slave
//          start/funct3/op_a/op_b : divide request from EX (held while stalled)
//          kill                   : EX flush, aborts any divide
//          cache_stall            : global memory stall, holds DONE
//          div_stall              : EX hold request
//          done/result            : result valid this cycle
//
// Build option: define DIV_EARLY_OUT_EN to skip the dividend's leading
// zeros at launch (shorter latency, identical results).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; fast-path results (div by 0, overflow) answered here
// BUSY  | one quotient bit per cycle, count down to 1
// DONE  | result presented; held while cache_stall is high
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     rst,
   div_unit_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] quot;      // dividend shifts out the top, quotient in the bottom
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   rem;
   logic             neg_q;
   logic             neg_r;
   logic             sel_rem;

   logic             go;
   logic             is_signed;
   logic             is_rem;
   logic             sign_a;
   logic             sign_b;
   logic             div0;
   logic             ovf;
   logic             zero_a;
   logic             fast;
   logic             launch;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] fast_result;
   logic [WIDTH-1:0] load_dividend;
   logic [CW-1:0]    load_count;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] raw;
   logic             neg_sel;
   logic [WIDTH-1:0] done_result;

   // funct3[2] is set for every M-extension divide; other encodings are ignored.
   assign go        = bus.start & bus.funct3[2] & ~bus.kill & ~rst;
   assign is_signed = ~bus.funct3[0];
   assign is_rem    = bus.funct3[1];
   assign sign_a    = is_signed & bus.op_a[WIDTH-1];
   assign sign_b    = is_signed & bus.op_b[WIDTH-1];
   assign mag_a     = sign_a ? -bus.op_a : bus.op_a;
   assign mag_b     = sign_b ? -bus.op_b : bus.op_b;
   assign div0      = (bus.op_b == '0);
   assign ovf       = is_signed & (bus.op_a == MIN_NEG) & (bus.op_b == '1);

`ifdef DIV_EARLY_OUT_EN
   logic [CW-1:0] lz;

   lzc #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_lzc (
      .value (mag_a),
      .count (lz)
   );

   assign zero_a        = (mag_a == '0);
   assign load_dividend = mag_a << lz;
   assign load_count    = (lz >= CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;
`else
   assign zero_a        = 1'b0;
   assign load_dividend = mag_a;
   assign load_count    = CW'(WIDTH);
`endif

   assign fast   = (state == IDLE) & go & (div0 | ovf | zero_a);
   assign launch = (state == IDLE) & go & ~(div0 | ovf | zero_a);

   // Priority: divide by zero, then signed overflow, then zero dividend.
   always_comb begin
      fast_result = '0;
      if (div0)
         fast_result = is_rem ? bus.op_a : '1;
      else if (ovf)
         fast_result = is_rem ? '0 : MIN_NEG;
   end

   // Remainder stays below the divisor, so rem[WIDTH] is 0 before the shift
   // and trial[WIDTH+1] is the borrow of the trial subtraction.
   assign rem_shift = {rem[WIDTH-1:0], quot[WIDTH-1]};
   assign trial     = {1'b0, rem_shift} - {2'b00, divisor};

   assign raw         = sel_rem ? rem[WIDTH-1:0] : quot;
   assign neg_sel     = sel_rem ? neg_r : neg_q;
   assign done_result = neg_sel ? -raw : raw;

   always_comb begin
      bus.div_stall = 1'b0;
      bus.done      = 1'b0;
      bus.result    = '0;
      if (!bus.kill && !rst) begin
         if (fast) begin
            bus.done   = 1'b1;
            bus.result = fast_result;
         end else if (launch || state == BUSY) begin
            bus.div_stall = 1'b1;
         end else if (state == DONE) begin
            bus.done   = 1'b1;
            bus.result = done_result;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         quot    <= '0;
         divisor <= '0;
         rem     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         sel_rem <= 1'b0;
      end else if (bus.kill) begin
         state   <= IDLE;
         count   <= '0;
         quot    <= '0;
         divisor <= '0;
         rem     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         sel_rem <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  quot    <= load_dividend;
                  divisor <= mag_b;
                  rem     <= '0;
                  count   <= load_count;
                  neg_q   <= sign_a ^ sign_b;
                  neg_r   <= sign_a;
                  sel_rem <= is_rem;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (trial[WIDTH+1]) begin
                  rem  <= rem_shift;
                  quot <= {quot[WIDTH-2:0], 1'b0};
               end else begin
                  rem  <= trial[WIDTH:0];
                  quot <= {quot[WIDTH-2:0], 1'b1};
               end
               count <= count - CW'(1);
               if (count == CW'(1))
                  state <= DONE;
            end
            DONE: begin
               // start is still the same instruction here; never relaunch.
               if (!bus.cache_stall)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 RV32M divider in the EXECUTE stage. Executes DIV, DIVU, REM and REMU.
- Drives div_stall, which freezes fetch, decode and execute and inserts bubbles into the EX/MEM register.
- Drives result, which the EX output mux feeds to the EX/MEM register when done is high.

Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  valid divide instruction in EX (decoder-gated, M-extension only).
- funct3  in  3  100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
- op_a  in  WIDTH  dividend (forwarded rs1).
- op_b  in  WIDTH  divisor (forwarded rs2).
- kill  in  1  EX flush; aborts any in-flight divide.
- cache_stall  in  1  global memory stall.
- div_stall  out  1  EX must hold; EX/MEM inserts a bubble.
- done  out  1  result valid this cycle.
- result  out  WIDTH  quotient or remainder.

Behaviour:
- Reset: state IDLE, all datapath registers 0, div_stall 0, done 0, result 0. Reset mid-operation discards the divide immediately.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start=0: div_stall 0, done 0, result 0.
- IDLE, start=1, fast path (divide by zero or signed overflow): result is combinational, done 1, div_stall 0, state stays IDLE.
  - Divide by zero: quotient all-ones; remainder = op_a.
  - Signed overflow (DIV/REM, op_a = 0x80000000, op_b = 0xFFFFFFFF): quotient 0x80000000; remainder 0.
- IDLE, start=1, normal path:
  - Latch |op_a|, |op_b|, the quotient negate flag (signs differ, signed ops only), the remainder negate flag (op_a negative, signed ops only), and the quotient/remainder select.
  - Load count = WIDTH. div_stall 1 this cycle. Next state BUSY.
- BUSY: restoring shift-subtract producing one quotient bit per cycle; count decrements. div_stall 1. At count=1 go to DONE. BUSY ignores cache_stall because EX is frozen anyway.
- DONE: div_stall 0, done 1. Result is the registered quotient or remainder, two's-complement negated if its negate flag is set.
  - cache_stall=1: hold DONE, result stable.
  - Otherwise: go to IDLE. The start seen in DONE is the same instruction, so it never relaunches.
- Latency, normal path: div_stall high for WIDTH+1 cycles (33); result valid on cycle WIDTH+1 after launch.
- Back-to-back divides: the second launches the cycle after DONE exits to IDLE.
- kill in any state: next state IDLE, datapath registers cleared. div_stall is forced to 0 in the kill cycle.
- kill has priority over start and over cache_stall.
- All arithmetic is WIDTH bits unsigned on magnitudes. Remainder register is WIDTH+1 bits so the trial subtraction can hold the borrow.

Optional Feature:
- DIV_EARLY_OUT_EN
  - Defined: at launch, count leading zeros of |op_a|, pre-shift the dividend left by that amount, and load count = WIDTH − clz (minimum 1). op_a = 0 takes the fast path (quotient 0, remainder 0).
  - Undefined: fixed count = WIDTH and no leading-zero logic; op_a = 0 uses the normal path.
- Results are identical either way; only latency differs.

Decomposition:
- Package div_pkg:
  - funct3 localparams F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - State enum div_state_t {IDLE, BUSY, DONE}.
  - Count width $clog2(WIDTH+1).
- One sub-module lzc: leading-zero counter, instantiated only under DIV_EARLY_OUT_EN.

Test Plan:
- DIVU 100/7 then REMU 100/7 -> result 14, then 2. div_stall high exactly 33 cycles each; done pulses 1 cycle; second launch the cycle after the first DONE.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIV 7/−2 -> 0xFFFFFFFD. REM 7/−2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. All four: done same cycle, div_stall never high.
- kill on BUSY cycle 10 -> div_stall 0 that cycle, state IDLE next cycle, no done pulse. A new DIVU 9/3 launched afterwards -> 3.
- cache_stall high for 3 cycles entering DONE -> done and result (0x0000000E) held for 4 cycles, div_stall 0 throughout.
- rst pulse mid-BUSY -> all outputs 0 immediately; with DIV_EARLY_OUT_EN, DIVU 100/7 -> 14 with div_stall high 8 cycles.
